// File: rtl/si_pkg.sv
// si_pkg: shared fleet geometry and game-state encoding for the fleet, formatter and player.
// Provides FLEET_COLS (formation width), LINE_W (line index width) and fleet_state_e.
package si_pkg;
  localparam int FLEET_COLS = 20;
  localparam int LINE_W = 5;
  typedef enum logic [1:0] {IDLE, RUN, WON, LOST} fleet_state_e;
endpackage

// File: rtl/invader_fleet_if.sv
// invader_fleet_if: control, bullet and formation signals between the fleet and its neighbours.
// master drives enable/start/bullet_*, slave (the fleet) drives formation, hit and end flags.
interface invader_fleet_if;
  import si_pkg::*;
  logic enable;
  logic start;
  logic [LINE_W-1:0] bullet_x;
  logic [LINE_W-1:0] bullet_y;
  logic bullet_active;
  logic [FLEET_COLS-1:0] inv_array;
  logic [LINE_W-1:0] inv_line;
  logic dir_right;
  logic hit;
  logic fleet_cleared;
  logic fleet_landed;
  modport master (
    output enable, start, bullet_x, bullet_y, bullet_active,
    input inv_array, inv_line, dir_right, hit, fleet_cleared, fleet_landed
  );
  modport slave (
    input enable, start, bullet_x, bullet_y, bullet_active,
    output inv_array, inv_line, dir_right, hit, fleet_cleared, fleet_landed
  );
endinterface

// File: rtl/invader_fleet_step.sv
// step_timer: march step divider with a period that shrinks on every hit down to a floor.
// clk/clr (sync active-low), load restarts counter and period, en counts, dec shortens period, tick marks a step.
module step_timer #(
  parameter int STEP_CYCLES = 3_000_000,
  parameter int MIN_STEP = 300_000,
  parameter int SPEEDUP = 120_000
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  logic dec,
  output logic tick
);
  localparam int CW = $clog2(STEP_CYCLES + 1);
  localparam logic [CW-1:0] P_INIT = CW'(STEP_CYCLES);
  localparam logic [CW-1:0] P_MIN = CW'(MIN_STEP);
  localparam logic [CW-1:0] P_SUB = CW'(SPEEDUP);
  logic [CW-1:0] cnt, period;
  // >= rather than == so a period that shrank under the counter still ticks next time
  assign tick = en && cnt >= period - CW'(1);
  always_ff @(posedge clk)
    if (!clr || load) begin
      cnt <= '0;
      period <= P_INIT;
    end else begin
      if (en) cnt <= tick ? '0 : cnt + CW'(1);
      if (dec) period <= period - P_MIN >= P_SUB ? period - P_SUB : P_MIN;
    end
endmodule

// File: rtl/invader_fleet.sv
// invader_fleet: marches the invader formation, resolves bullet hits and reports win/loss.
// clk, clr (sync active-low) plus bus (slave): enable/start/bullet inputs, formation, hit and end flags out.
module invader_fleet import si_pkg::*; #(
  parameter logic [FLEET_COLS-1:0] INIT_ARRAY = 20'b00101010101010101010,
  parameter logic [LINE_W-1:0] INIT_LINE = 5'd4,
  parameter logic [LINE_W-1:0] LAND_LINE = 5'd28,
  parameter int STEP_CYCLES = 3_000_000,
  parameter int MIN_STEP = 300_000,
  parameter int SPEEDUP = 120_000
) (
  input logic clk,
  input logic clr,
  invader_fleet_if.slave bus
);
  fleet_state_e state, state_n;
  logic [FLEET_COLS-1:0] inv_array, arr_n, mask, a;
  logic [LINE_W-1:0] inv_line, line_n;
  logic dir_right, dir_n, hit, hit_c, tick, load, edge_occ;
  step_timer #(.STEP_CYCLES(STEP_CYCLES), .MIN_STEP(MIN_STEP), .SPEEDUP(SPEEDUP)) u_timer (
    .clk(clk),
    .clr(clr),
    .load(load),
    .en(bus.enable && state == RUN),
    .dec(hit_c),
    .tick(tick)
  );
  always_comb begin
    // shifting past the last column yields an empty mask, so x >= 20 never hits
    mask = FLEET_COLS'(1) << bus.bullet_x;
    hit_c = state == RUN && bus.bullet_active && bus.bullet_y == inv_line && |(inv_array & mask);
    a = hit_c ? inv_array & ~mask : inv_array;
    edge_occ = dir_right ? a[FLEET_COLS-1] : a[0];
    load = bus.start && state != RUN;
    state_n = state;
    arr_n = inv_array;
    line_n = inv_line;
    dir_n = dir_right;
    if (load) begin
      state_n = RUN;
      arr_n = INIT_ARRAY;
      line_n = INIT_LINE;
      dir_n = 1'b1;
    end else if (state == RUN) begin
      arr_n = a;
      if (a == '0) state_n = WON;
      else if (tick && edge_occ) begin
        line_n = inv_line + LINE_W'(1);
        dir_n = !dir_right;
        state_n = line_n == LAND_LINE ? LOST : RUN;
      end else if (tick) arr_n = dir_right ? a << 1 : a >> 1;
    end
  end
  always_ff @(posedge clk)
    if (!clr) begin
      state <= IDLE;
      inv_array <= INIT_ARRAY;
      inv_line <= INIT_LINE;
      dir_right <= 1'b1;
      hit <= 1'b0;
    end else begin
      state <= state_n;
      inv_array <= arr_n;
      inv_line <= line_n;
      dir_right <= dir_n;
      hit <= hit_c;
    end
  assign bus.inv_array = inv_array;
  assign bus.inv_line = inv_line;
  assign bus.dir_right = dir_right;
  assign bus.hit = hit;
  assign bus.fleet_cleared = state == WON;
  assign bus.fleet_landed = state == LOST;
endmodule
